// File: rtl/gpu_pkg.sv
// Shared types and defaults for the LSU-to-memory controller slice.
// Channel state encoding and default bus widths live here.
package gpu_pkg;

   localparam int ADDR_BITS_DEF = 8;
   localparam int DATA_BITS_DEF = 8;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      READ_WAIT   = 3'd1,
      WRITE_WAIT  = 3'd2,
      READ_RELAY  = 3'd3,
      WRITE_RELAY = 3'd4
   } ctrl_state_t;

   function automatic int id_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One memory channel: latches a granted request, runs the memory
// handshake and holds the consumer ready until the consumer lets go.
module mem_channel_fsm
   import gpu_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int ID_BITS   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 grant,
   input  logic [ID_BITS-1:0]   grant_id,
   input  logic                 grant_read,
   input  logic [ADDR_BITS-1:0] grant_address,
   input  logic [DATA_BITS-1:0] grant_data,
   input  logic                 read_valid,
   input  logic                 write_valid,
   input  logic                 mem_read_ready,
   input  logic                 mem_write_ready,
   output ctrl_state_t          state,
   output logic [ID_BITS-1:0]   owner,
   output logic                 mem_read_valid,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] address,
   output logic [DATA_BITS-1:0] data,
   output logic                 read_done,
   output logic                 write_done,
   output logic                 read_free,
   output logic                 write_free
);

   ctrl_state_t          state_n;
   logic [ID_BITS-1:0]   owner_n;
   logic                 rvalid_n;
   logic                 wvalid_n;
   logic [ADDR_BITS-1:0] address_n;
   logic [DATA_BITS-1:0] data_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         owner           <= '0;
         mem_read_valid  <= 1'b0;
         mem_write_valid <= 1'b0;
         address         <= '0;
         data            <= '0;
      end else begin
         state           <= state_n;
         owner           <= owner_n;
         mem_read_valid  <= rvalid_n;
         mem_write_valid <= wvalid_n;
         address         <= address_n;
         data            <= data_n;
      end
   end

   always_comb begin
      state_n    = state;
      owner_n    = owner;
      rvalid_n   = mem_read_valid;
      wvalid_n   = mem_write_valid;
      address_n  = address;
      data_n     = data;
      read_done  = 1'b0;
      write_done = 1'b0;
      read_free  = 1'b0;
      write_free = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant) begin
               owner_n   = grant_id;
               address_n = grant_address;
               if (grant_read) begin
                  rvalid_n = 1'b1;
                  state_n  = READ_WAIT;
               end else begin
                  data_n   = grant_data;
                  wvalid_n = 1'b1;
                  state_n  = WRITE_WAIT;
               end
            end
         end
         READ_WAIT: begin
            if (mem_read_ready) begin
               rvalid_n  = 1'b0;
               read_done = 1'b1;
               state_n   = READ_RELAY;
            end
         end
         WRITE_WAIT: begin
            if (mem_write_ready) begin
               wvalid_n   = 1'b0;
               write_done = 1'b1;
               state_n    = WRITE_RELAY;
            end
         end
         READ_RELAY: begin
            if (!read_valid) begin
               read_free = 1'b1;
               state_n   = IDLE;
            end
         end
         WRITE_RELAY: begin
            if (!write_valid) begin
               write_free = 1'b1;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: rtl/mem_controller.sv
// Round-robin arbiter from per-thread LSU ports onto memory channels.
// Owns the claim mask, the rr pointer and the cross-channel grant chain.
module mem_controller
   import gpu_pkg::*;
#(
   parameter int ADDR_BITS     = ADDR_BITS_DEF,
   parameter int DATA_BITS     = DATA_BITS_DEF,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   localparam int ID_BITS = id_bits(NUM_CONSUMERS);

   ctrl_state_t          ch_state      [NUM_CHANNELS];
   logic [ID_BITS-1:0]   ch_owner      [NUM_CHANNELS];
   logic [ADDR_BITS-1:0] ch_address    [NUM_CHANNELS];
   logic [DATA_BITS-1:0] ch_data       [NUM_CHANNELS];
   logic                 ch_rvalid     [NUM_CHANNELS];
   logic                 ch_wvalid     [NUM_CHANNELS];
   logic                 ch_read_done  [NUM_CHANNELS];
   logic                 ch_write_done [NUM_CHANNELS];
   logic                 ch_read_free  [NUM_CHANNELS];
   logic                 ch_write_free [NUM_CHANNELS];
   logic                 grant         [NUM_CHANNELS];
   logic [ID_BITS-1:0]   grant_id      [NUM_CHANNELS];
   logic                 grant_read    [NUM_CHANNELS];
   logic [ADDR_BITS-1:0] grant_address [NUM_CHANNELS];
   logic [DATA_BITS-1:0] grant_data    [NUM_CHANNELS];

   logic [NUM_CONSUMERS-1:0] claim;
   logic [NUM_CONSUMERS-1:0] claim_n;
   logic [NUM_CONSUMERS-1:0] taken;
   logic [NUM_CONSUMERS-1:0] freed;
   logic [NUM_CONSUMERS-1:0] request;
   logic [ID_BITS-1:0]       rr;
   logic [ID_BITS-1:0]       rr_n;
   logic [ID_BITS-1:0]       top_id;
   logic                     any_grant;
   int                       idx;

   assign request = consumer_read_valid | consumer_write_valid;

   // Channels are chained: a lower channel's pick is masked for the rest.
   always_comb begin
      taken     = '0;
      freed     = '0;
      top_id    = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         grant[c]         = 1'b0;
         grant_id[c]      = '0;
         grant_read[c]    = 1'b0;
         grant_address[c] = '0;
         grant_data[c]    = '0;
         if (ch_state[c] == IDLE) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
               idx = int'(rr) + k;
               if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
               if (!grant[c] && request[idx] && !claim[idx] && !taken[idx]) begin
                  grant[c]    = 1'b1;
                  grant_id[c] = ID_BITS'(idx);
               end
            end
         end
         if (grant[c]) begin
            taken[grant_id[c]] = 1'b1;
            grant_read[c]      = consumer_read_valid[grant_id[c]];
            grant_address[c]   = grant_read[c]
               ? consumer_read_address[grant_id[c]*ADDR_BITS +: ADDR_BITS]
               : consumer_write_address[grant_id[c]*ADDR_BITS +: ADDR_BITS];
            grant_data[c] = consumer_write_data[grant_id[c]*DATA_BITS +: DATA_BITS];
            if (!any_grant || grant_id[c] > top_id) top_id = grant_id[c];
            any_grant = 1'b1;
         end
         if (ch_read_free[c] || ch_write_free[c]) freed[ch_owner[c]] = 1'b1;
      end
      claim_n = (claim & ~freed) | taken;
      rr_n    = rr;
      if (any_grant) begin
         if (int'(top_id) == NUM_CONSUMERS - 1) rr_n = '0;
         else rr_n = top_id + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         claim                <= '0;
         rr                   <= '0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         consumer_read_data   <= '0;
      end else begin
         claim <= claim_n;
         rr    <= rr_n;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_read_done[c]) begin
               consumer_read_ready[ch_owner[c]] <= 1'b1;
               consumer_read_data[ch_owner[c]*DATA_BITS +: DATA_BITS]
                  <= mem_read_data[c*DATA_BITS +: DATA_BITS];
            end
            if (ch_write_done[c]) consumer_write_ready[ch_owner[c]] <= 1'b1;
            if (ch_read_free[c])  consumer_read_ready[ch_owner[c]]  <= 1'b0;
            if (ch_write_free[c]) consumer_write_ready[ch_owner[c]] <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      assign ch_rvalid[g] = consumer_read_valid[ch_owner[g]];
      assign ch_wvalid[g] = consumer_write_valid[ch_owner[g]];
      assign mem_read_address[g*ADDR_BITS +: ADDR_BITS]  = ch_address[g];
      assign mem_write_address[g*ADDR_BITS +: ADDR_BITS] = ch_address[g];
      assign mem_write_data[g*DATA_BITS +: DATA_BITS]    = ch_data[g];

      mem_channel_fsm #(
         .ADDR_BITS (ADDR_BITS),
         .DATA_BITS (DATA_BITS),
         .ID_BITS   (ID_BITS)
      ) u_ch (
         .clk             (clk),
         .reset           (reset),
         .grant           (grant[g]),
         .grant_id        (grant_id[g]),
         .grant_read      (grant_read[g]),
         .grant_address   (grant_address[g]),
         .grant_data      (grant_data[g]),
         .read_valid      (ch_rvalid[g]),
         .write_valid     (ch_wvalid[g]),
         .mem_read_ready  (mem_read_ready[g]),
         .mem_write_ready (mem_write_ready[g]),
         .state           (ch_state[g]),
         .owner           (ch_owner[g]),
         .mem_read_valid  (mem_read_valid[g]),
         .mem_write_valid (mem_write_valid[g]),
         .address         (ch_address[g]),
         .data            (ch_data[g]),
         .read_done       (ch_read_done[g]),
         .write_done      (ch_write_done[g]),
         .read_free       (ch_read_free[g]),
         .write_free      (ch_write_free[g])
      );
   end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Arbitrates the per-thread LSU memory request ports of a core onto a smaller number of external memory channels.
- Sits directly downstream of the LSUs. It consumes their read/write valid, address and data, and returns ready and read data.
- Each memory channel runs an independent transaction FSM. Free consumers are granted round-robin.
- Read and write paths share the arbitration but use separate memory-side handshakes.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, data width.
- NUM_CONSUMERS, 4, number of LSU request ports (≥1).
- NUM_CHANNELS, 1, number of memory channels (1..NUM_CONSUMERS).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer i at [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  read completed, data valid.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data.
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed.
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed.
- consumer_write_ready  out  NUM_CONSUMERS  write completed.
- mem_read_valid  out  NUM_CHANNELS  memory read request.
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  packed.
- mem_read_ready  in  NUM_CHANNELS  memory read done.
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  packed, sampled when ready.
- mem_write_valid  out  NUM_CHANNELS  memory write request.
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  packed.
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  packed.
- mem_write_ready  in  NUM_CHANNELS  memory write done.

Behaviour:
- Reset:
  - All outputs 0, all channels IDLE, claim mask 0, round-robin pointer 0.
  - Reset mid-transaction drops the transaction; the memory side must tolerate valid falling without ready.
- Registered outputs: all outputs are registered, so no combinational path from any input to any output.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE:
  - The channel scans consumers from rr_ptr upward, modulo NUM_CONSUMERS.
  - It picks the first consumer that has read_valid or write_valid, is not claimed, and was not picked by a lower-index channel in the same cycle.
  - On a pick it sets the claim bit, latches the address (and data for writes), and asserts mem_*_valid on the next edge.
  - Next state is READ_WAIT or WRITE_WAIT.
  - If a consumer asserts both read and write (illegal), the read wins.
- Round-robin pointer: after any grant, rr_ptr becomes (highest-granted-consumer + 1) mod NUM_CONSUMERS.
- READ_WAIT: when mem_read_ready=1, mem_read_valid←0, consumer_read_data←mem_read_data, consumer_read_ready←1, next state READ_RELAY.
- WRITE_WAIT: when mem_write_ready=1, mem_write_valid←0, consumer_write_ready←1, next state WRITE_RELAY.
- READ_RELAY / WRITE_RELAY:
  - Hold ready high until the consumer's matching valid is sampled low.
  - Then ready←0, claim bit cleared, next state IDLE.
  - The freed consumer can be re-granted one cycle later, never in the same cycle.
- consumer_read_data holds its value after ready falls, until the next read completes for that consumer.
- Latency: request valid sampled at edge E0 → mem valid high after E0 → memory ready at edge Ek → consumer ready high after Ek.
  - Minimum consumer-valid-to-consumer-ready is 2 cycles with a ready-immediately memory.
- Memory-side address and data stay stable while mem_*_valid is high.
- At most one channel serves a given consumer at any time.

Decomposition:
- Shared package gpu_pkg: channel state enum (ctrl_state_t, 3 bits) and the default ADDR_BITS/DATA_BITS constants.
- Natural sub-module: mem_channel_fsm, one instance per channel. It holds the state, latched consumer id, address/data and handshake registers.
- The top level keeps the claim mask, rr_ptr and the combinational grant chain across channels.

Test Plan:
- Single read: consumer 0 read addr 0x12, memory returns 0xAB with a 1-cycle ready → mem_read_address=0x12; consumer_read_ready[0]=1 with data 0xAB; ready falls one cycle after valid drops.
- Single write: consumer 2 writes 0x55 to 0x30 → mem_write_address=0x30, data 0x55; consumer_write_ready[2] pulses; mem_write_valid low after mem_write_ready.
- Contention, NUM_CHANNELS=1: all 4 consumers request reads at once → served in order 0,1,2,3; no consumer starved; exactly one mem_read_valid transaction at a time.
- Two channels, 3 simultaneous requests (consumers 1,2,3) → channel 0 takes 1, channel 1 takes 2; consumer 3 is granted after the first release; no consumer is ever granted twice.
- Relay hold: consumer keeps read_valid high 3 cycles after ready → ready stays high and no regrant occurs; release happens one cycle after valid drops.
- Reset during READ_WAIT → all valids and readies 0 next cycle; a fresh request afterwards completes normally with rr_ptr=0.
